// File: rtl/pooling_sequencer_if.sv
// pooling_sequencer_if
//   Bundles the column-pacing handshake, the per-unit ALU control word, the
//   window strobes and the result handshake between the pooling sequencer
//   and the line buffer / pooling ALU array / downstream accumulator.
//
// Parameters
//   depth    : log2 of the number of ALU units (D = 1 << depth)
//
// Signals
//   inValid  : buffer presents a column
//   inReady  : sequencer accepts the column (fire = inValid && inReady)
//   ctl      : unit i control at [4i+3:4i] = {write,useUpper,useCurrent,useLower}
//   accFirst : fired column opens a horizontal window
//   accLast  : fired column closes a horizontal window
//   outValid : window result ready downstream
//   outReady : downstream accepts the result
//
// Modports
//   master : sequencer side
//   slave  : buffer / ALU array / downstream side
interface pooling_sequencer_if #(
  parameter int depth = 2
);
  localparam int D = 1 << depth;

  logic           inValid;
  logic           inReady;
  logic [4*D-1:0] ctl;
  logic           accFirst;
  logic           accLast;
  logic           outValid;
  logic           outReady;

  modport master (
    input  inValid, outReady,
    output inReady, ctl, accFirst, accLast, outValid
  );

  modport slave (
    output inValid, outReady,
    input  inReady, ctl, accFirst, accLast, outValid
  );
endinterface

// File: rtl/pooling_sequencer.sv
// pooling_sequencer
//   Turns a pooling job (window size K, column count) into per-unit 4-bit
//   control words for a column of D pooling ALUs, paces input columns with a
//   valid/ready handshake, emits window-boundary strobes and holds a one-deep
//   result slot towards downstream.
//
// Parameters
//   depth : log2 of unit count (D = 1 << depth)
//   CW    : width of the column-count configuration
//
// Ports
//   CLK, RESETn     : clock, asynchronous active-low reset
//   start           : job start pulse, only honoured in IDLE
//   cfgK            : window size 1..3 (0 behaves as 1)
//   cfgCols         : number of input columns in the job
//   bus (master)    : inValid/inReady, ctl, accFirst/accLast, outValid/outReady
//   busy            : a job is in progress
//   done            : one-cycle pulse when a job completes
//
// Build option
//   POOL_PAD_EN : when defined, a trailing partial window is closed on the
//                 last column and emitted; otherwise trailing columns are
//                 consumed with write held low and produce no result.
module pooling_sequencer #(
  parameter int depth = 2,
  parameter int CW    = 16
) (
  input  logic                CLK,
  input  logic                RESETn,
  input  logic                start,
  input  logic [1:0]          cfgK,
  input  logic [CW-1:0]       cfgCols,
  pooling_sequencer_if.master bus,
  output logic                busy,
  output logic                done
);
  localparam int D = 1 << depth;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t         state_q, state_d;
  logic [1:0]     k_q, k_d;
  logic [CW-1:0]  cols_q, cols_d;
  logic [CW-1:0]  col_cnt_q, col_cnt_d;
  logic [1:0]     win_pos_q, win_pos_d;
  logic           out_valid_q, out_valid_d;
  logic           done_q, done_d;

  logic           in_ready;
  logic           fire;
  logic           last_col;
  logic           win_last;
  logic           tail_col;
  logic           acc_hit;
  logic           acc_first;
  logic           acc_last;
  logic [4*D-1:0] ctl_hold;
  logic [4*D-1:0] ctl_wmask;
  logic [4*D-1:0] ctl;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q     <= IDLE;
      k_q         <= 2'd0;
      cols_q      <= '0;
      col_cnt_q   <= '0;
      win_pos_q   <= 2'd0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      cols_q      <= cols_d;
      col_cnt_q   <= col_cnt_d;
      win_pos_q   <= win_pos_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  // Window bookkeeping. A column belongs to a trailing partial window when
  // the columns left from its window start are fewer than K; that is
  // (cols - colCnt + winPos) < K, which holds for every column of that window.
  always_comb begin
    last_col = (col_cnt_q == cols_q - 1'b1);
    win_last = (win_pos_q == k_q - 2'd1);
`ifdef POOL_PAD_EN
    tail_col = 1'b0;
    acc_hit  = win_last || last_col;
`else
    tail_col = ({1'b0, cols_q - col_cnt_q} + {{(CW-1){1'b0}}, win_pos_q})
               < {{(CW-1){1'b0}}, k_q};
    acc_hit  = win_last;
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (cfgCols == '0) ? FLUSH : RUN;
      RUN:     if (fire && last_col) state_d = FLUSH;
      FLUSH:   if (!out_valid_q || bus.outReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake, strobes and the vertical control pattern. The pattern depends
  // only on the latched K; the write bit alone follows fire.
  always_comb begin
    in_ready  = (state_q == RUN) && !(out_valid_q && !bus.outReady);
    fire      = bus.inValid && in_ready;
    acc_first = fire && (win_pos_q == 2'd0);
    acc_last  = fire && acc_hit;
    ctl_hold  = '0;
    ctl_wmask = '0;
    if (state_q == RUN) begin
      for (int i = 0; i < D; i++) begin
        case (k_q)
          2'd2: begin
            if (i % 2 == 0) begin
              ctl_hold[4*i +: 4] = 4'b0011;
              ctl_wmask[4*i+3]   = 1'b1;
            end
          end
          2'd3: begin
            // Centres sit at i%3==1; a unit left alone at the bottom acts
            // as a lone centre without neighbours.
            if (i % 3 == 1) begin
              ctl_hold[4*i +: 4] = (i == D-1) ? 4'b0110 : 4'b0111;
              ctl_wmask[4*i+3]   = 1'b1;
            end else if ((i % 3 == 0) && (i == D-1)) begin
              ctl_hold[4*i +: 4] = 4'b0010;
              ctl_wmask[4*i+3]   = 1'b1;
            end
          end
          default: begin
            ctl_hold[4*i +: 4] = 4'b0010;
            ctl_wmask[4*i+3]   = 1'b1;
          end
        endcase
      end
    end
    ctl = ctl_hold | (ctl_wmask & {(4*D){fire && !tail_col}});
  end

  always_comb begin
    k_d         = k_q;
    cols_d      = cols_q;
    col_cnt_d   = col_cnt_q;
    win_pos_d   = win_pos_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    if (state_q == IDLE && start) begin
      k_d       = (cfgK == 2'd0) ? 2'd1 : cfgK;
      cols_d    = cfgCols;
      col_cnt_d = '0;
      win_pos_d = 2'd0;
    end
    if (fire) begin
      col_cnt_d = col_cnt_q + 1'b1;
      win_pos_d = acc_last ? 2'd0 : win_pos_q + 2'd1;
    end
    // A closing column can only fire while the slot is empty or draining,
    // so setting takes priority over clearing.
    if (acc_last) begin
      out_valid_d = 1'b1;
    end else if (out_valid_q && bus.outReady) begin
      out_valid_d = 1'b0;
    end
    if (state_q == FLUSH && state_d == IDLE) done_d = 1'b1;
  end

  assign bus.inReady  = in_ready;
  assign bus.ctl      = ctl;
  assign bus.accFirst = acc_first;
  assign bus.accLast  = acc_last;
  assign bus.outValid = out_valid_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
endmodule

// File: tb/tb_pooling_sequencer.sv
// tb_pooling_sequencer
//   Drives pooling jobs with randomized inValid/outReady pacing and compares
//   every cycle against a job-level reference model (columns fired, pending
//   result, window arithmetic from K and the column count).
module tb_pooling_sequencer;
  localparam int DEPTH = 2;
  localparam int D     = 1 << DEPTH;
  localparam int CW    = 16;
`ifdef POOL_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic           CLK     = 1'b0;
  logic           RESETn  = 1'b0;
  logic           start   = 1'b0;
  logic [1:0]     cfgK    = 2'd0;
  logic [CW-1:0]  cfgCols = '0;
  logic           busy;
  logic           done;

  int checks = 0;
  int errors = 0;
  int lat;

  pooling_sequencer_if #(.depth(DEPTH)) bus ();

  pooling_sequencer #(.depth(DEPTH), .CW(CW)) dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .start  (start),
    .cfgK   (cfgK),
    .cfgCols(cfgCols),
    .bus    (bus),
    .busy   (busy),
    .done   (done)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit s, input logic [1:0] k, input logic [CW-1:0] c,
                               input bit v, input bit r);
    start        = s;
    cfgK         = k;
    cfgCols      = c;
    bus.inValid  = v;
    bus.outReady = r;
  endtask

  // Unit control word expected from the window-size rules.
  function automatic logic [4*D-1:0] expCtl(input int k, input bit run, input bit wr);
    logic [4*D-1:0] r;
    logic [3:0]     u;
    r = '0;
    for (int i = 0; i < D; i++) begin
      u = 4'b0000;
      if (run) begin
        if (k == 1) u = 4'b0010;
        else if (k == 2) begin
          if (i % 2 == 0) u = 4'b0011;
        end else begin
          if (i % 3 == 1) u = (i == D-1) ? 4'b0110 : 4'b0111;
          else if (i % 3 == 0 && i == D-1) u = 4'b0010;
        end
        if (u != 4'b0000 && wr) u[3] = 1'b1;
      end
      r[4*i +: 4] = u;
    end
    return r;
  endfunction

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"},     busy,         0);
    checkOutput({tag, "_inReady"},  bus.inReady,  0);
    checkOutput({tag, "_ctl"},      bus.ctl,      0);
    checkOutput({tag, "_accFirst"}, bus.accFirst, 0);
    checkOutput({tag, "_accLast"},  bus.accLast,  0);
    checkOutput({tag, "_outValid"}, bus.outValid, 0);
    checkOutput({tag, "_done"},     done,         0);
  endtask

  // Runs one job from the cycle start is raised to the cycle after done.
  // pv/pr are percent probabilities of inValid/outReady each cycle.
  task automatic runJob(input int k, input int cols, input int pv, input int pr,
                        input bit stallMode, input bit spurious, output int latency);
    int kk, phase, j, emitted, nf, expOut, stall;
    bit ov, doneExp, nextDone, firstLast, finished, full;
    bit inRdyE, fireE, aFirstE, aLastE;
    logic [4*D-1:0] ctlE;
    kk = (k == 0) ? 1 : k;
    phase = 0; j = 0; emitted = 0; stall = 0;
    ov = 0; doneExp = 0; firstLast = 0; finished = 0;
    nf = cols / kk;
    expOut = PAD ? (cols + kk - 1) / kk : nf;
    latency = -1;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      if (cyc == 0)
        applyStimulus(1'b1, k[1:0], cols[CW-1:0], 1'b0, 1'b0);
      else
        applyStimulus(spurious && cyc == 3, 2'($urandom), CW'($urandom_range(0, 20)), 1'b0, 1'b0);
      bus.inValid = ($urandom_range(0, 99) < pv);
      if (stallMode && stall > 0) begin
        bus.outReady = 1'b0;
        stall--;
      end else begin
        bus.outReady = ($urandom_range(0, 99) < pr);
      end
      @(negedge CLK);
      inRdyE  = (phase == 1) && !(ov && !bus.outReady);
      fireE   = bus.inValid && inRdyE;
      full    = (j < nf * kk);
      aFirstE = fireE && (j % kk == 0);
      aLastE  = fireE && ((full && (j % kk == kk - 1)) || (PAD && j == cols - 1));
      ctlE    = expCtl(kk, phase == 1, fireE && (PAD || full));
      checkOutput("inReady",  bus.inReady,  inRdyE);
      checkOutput("accFirst", bus.accFirst, aFirstE);
      checkOutput("accLast",  bus.accLast,  aLastE);
      checkOutput("ctl",      bus.ctl,      ctlE);
      checkOutput("outValid", bus.outValid, ov);
      checkOutput("busy",     busy,         phase != 0);
      checkOutput("done",     done,         doneExp);
      if (doneExp) begin
        latency  = cyc;
        finished = 1;
      end
      @(posedge CLK);
      #1;
      nextDone = 0;
      if (phase == 0 && cyc == 0) phase = (cols == 0) ? 2 : 1;
      else if (phase == 1) begin
        if (fireE && j + 1 == cols) phase = 2;
      end else if (phase == 2) begin
        if (!ov || bus.outReady) begin
          phase    = 0;
          nextDone = 1;
        end
      end
      if (ov && bus.outReady) emitted++;
      if (aLastE) ov = 1;
      else if (ov && bus.outReady) ov = 0;
      if (fireE) j++;
      if (aLastE && !firstLast) begin
        firstLast = 1;
        if (stallMode) stall = 5;
      end
      doneExp = nextDone;
    end
    start = 1'b0;
    checkOutput("job_finished", finished, 1);
    checkOutput("cols_fired",   j,        cols);
    checkOutput("outputs",      emitted,  expOut);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired before the summary");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    applyStimulus(1'b0, 2'd0, '0, 1'b1, 1'b1);
    RESETn = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checkIdleOutputs("reset");
    RESETn = 1'b1;
    @(posedge CLK);
    #1;

    $display("[TB] directed window jobs");
    runJob(1, 3, 100, 100, 1'b0, 1'b0, lat);
    runJob(2, 4, 100, 100, 1'b0, 1'b0, lat);
    runJob(3, 6, 100, 100, 1'b0, 1'b0, lat);
    runJob(2, 5, 100, 100, 1'b0, 1'b0, lat);
    runJob(2, 5, 60, 70, 1'b0, 1'b0, lat);
    runJob(0, 4, 70, 70, 1'b0, 1'b0, lat);
    runJob(3, 7, 80, 60, 1'b0, 1'b0, lat);
    runJob(3, 2, 100, 100, 1'b0, 1'b0, lat);

    $display("[TB] result back-pressure");
    runJob(2, 6, 100, 100, 1'b1, 1'b0, lat);
    runJob(1, 4, 100, 100, 1'b1, 1'b0, lat);

    $display("[TB] start while busy");
    runJob(2, 8, 100, 100, 1'b0, 1'b1, lat);

    $display("[TB] randomized jobs");
    for (int n = 0; n < 10; n++) begin
      runJob($urandom_range(0, 3), $urandom_range(0, 12), $urandom_range(30, 100),
             $urandom_range(30, 100), 1'b0, 1'b0, lat);
    end

    $display("[TB] reset mid-job");
    applyStimulus(1'b1, 2'd2, 16'd8, 1'b1, 1'b1);
    @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("midjob_busy", busy, 1);
    RESETn = 1'b0;
    #2;
    checkIdleOutputs("async_reset");
    @(posedge CLK);
    #1;
    RESETn = 1'b1;
    @(posedge CLK);
    #1;
    runJob(2, 0, 100, 100, 1'b0, 1'b0, lat);
    checkOutput("cols0_latency", lat, 2);
    runJob(3, 3, 100, 100, 1'b0, 1'b0, lat);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
